// File: rtl/approx_sweep_pkg.sv
// Shared types and arithmetic helpers for the approximate-multiplier sweep controller.
// Helpers work on 32-bit containers so that one definition serves every parameterisation.
package approx_sweep_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  // Operand a is the low half of vec and b the high half; the product is truncated to out_w bits.
  function automatic logic [31:0] exact_mul(input logic [31:0] vec, input int in_w, input int out_w);
    logic [31:0] half_mask;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    half_mask = (32'd1 << (in_w / 2)) - 32'd1;
    a = vec & half_mask;
    b = (vec >> (in_w / 2)) & half_mask;
    p = a * b;
    return (out_w >= 32) ? p : (p & ((32'd1 << out_w) - 32'd1));
  endfunction

  function automatic logic [32:0] abs_err(input logic [31:0] x, input logic [31:0] y);
    return (x >= y) ? {1'b0, x - y} : {1'b0, y - x};
  endfunction

endpackage

// File: rtl/approx_err_unit.sv
// Combinational error evaluation for one swept vector: saturated absolute error
// against the exact truncated product, plus the threshold violation flag.
module approx_err_unit
  import approx_sweep_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 4,
  parameter int ET    = 2
) (
  input  logic [IN_W-1:0]  vec,
  input  logic [OUT_W-1:0] dut_out,
  output logic [OUT_W-1:0] err,
  output logic             violate
);

  localparam logic [32:0] ERR_SAT = (33'd1 << OUT_W) - 33'd1;

  logic [31:0] exact;
  logic [32:0] diff;

  always_comb begin
    exact = exact_mul(32'(vec), IN_W, OUT_W);
    diff  = abs_err(exact, 32'(dut_out));
    err   = (diff > ERR_SAT) ? '1 : diff[OUT_W-1:0];
    violate = (32'(err) > 32'(ET));
  end

endmodule

// File: rtl/approx_mul_sweep_ctrl.sv
// Exhaustive sweep controller: walks every input vector through the approximate multiplier
// and accumulates error statistics. Define SWEEP_EARLY_ABORT_EN to stop at the first violation.
module approx_mul_sweep_ctrl
  import approx_sweep_pkg::*;
#(
  parameter int IN_W       = 4,
  parameter int OUT_W      = 4,
  parameter int ET         = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [IN_W-1:0] dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic            busy,
  output logic            done,
  output logic [OUT_W-1:0] max_err,
  output logic [IN_W:0]   err_count,
  output logic            pass,
  output logic [IN_W-1:0] fail_vec
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [IN_W-1:0] LAST_VEC    = '1;

  state_t          state;
  logic [CW-1:0]   settle_cnt;
  logic [OUT_W-1:0] err;
  logic            violate;
  logic            end_sweep;

  approx_err_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET)) u_err (
    .vec     (dut_in),
    .dut_out (dut_out),
    .err     (err),
    .violate (violate)
  );

  always_comb begin
`ifdef SWEEP_EARLY_ABORT_EN
    end_sweep = violate || (dut_in == LAST_VEC);
`else
    end_sweep = (dut_in == LAST_VEC);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      max_err    <= '0;
      err_count  <= '0;
      pass       <= 1'b0;
      fail_vec   <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            max_err    <= '0;
            err_count  <= '0;
            fail_vec   <= '0;
            pass       <= 1'b0;
            dut_in     <= '0;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt == '0) state <= CHECK;
          else settle_cnt <= settle_cnt - 1'b1;
        end
        CHECK: begin
          if (err > max_err) max_err <= err;
          // err_count still zero means this is the first violating vector of the sweep
          if (violate) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) fail_vec <= dut_in;
          end
          if (end_sweep) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            dut_in     <= dut_in + 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= DRIVE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (err_count == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/approx_mul_sweep_ctrl.md
Name: approx_mul_sweep_ctrl

Overview:
Exhaustive-sweep controller for a generated approximate multiplier netlist (IN_W inputs, OUT_W outputs).
- On start, drives every input vector into the combinational approximate multiplier under test.
- Compares each result with the exact product and accumulates worst-case error and the count of vectors exceeding the error threshold.
- Sits beside the approximate block in the characterisation/self-check wrapper and reports pass/fail against ET.

Parameters:
IN_W, 4, total multiplier input bits; operand a = vec[IN_W/2-1:0], operand b = vec[IN_W-1:IN_W/2]; must be even
OUT_W, 4, multiplier output width; exact product is truncated to OUT_W bits
ET, 2, error threshold; a vector violates when abs error > ET
SETTLE_CYC, 1, cycles dut_in is held before dut_out is sampled (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a sweep; accepted only in IDLE
dut_in  out  IN_W  registered input vector driven to the approximate multiplier
dut_out  in  OUT_W  combinational response of the approximate multiplier
busy  out  1  high from the cycle after start acceptance until DONE
done  out  1  one-cycle pulse at sweep completion
max_err  out  OUT_W  worst abs error seen in the current/last sweep
err_count  out  IN_W+1  number of violating vectors
pass  out  1  err_count==0; valid when done pulses, held until next start
fail_vec  out  IN_W  first violating vector; 0 if none

Behaviour:
- Reset (async, rst_n=0): state=IDLE; dut_in=0, busy=0, done=0, max_err=0, err_count=0, pass=0, fail_vec=0; settle counter=0.
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE: on start=1, clear max_err/err_count/fail_vec/pass, set vec=0, dut_in=0, load settle counter; go to DRIVE.
- DRIVE: dut_in holds vec for SETTLE_CYC cycles, then goes to CHECK.
- CHECK: sample dut_out.
  - exact = (a*b) mod 2^OUT_W.
  - err = |exact - dut_out|, computed OUT_W+1 wide and saturated to OUT_W.
  - max_err = max(max_err, err).
  - If err > ET: err_count++; fail_vec = vec if this is the first violation.
  - If vec == 2^IN_W-1, go to DONE; else vec++, dut_in=vec+1, go to DRIVE.
- DONE: done=1 for one cycle, pass=(err_count==0), busy=0; next cycle IDLE.
- Results hold until the next accepted start.
- busy=1 in DRIVE and CHECK only.
- start is ignored when not in IDLE, including during the DONE cycle.
- Latency: start accepted at edge 0; done at edge 2^IN_W*(SETTLE_CYC+1)+1. Defaults give edge 33.
- err_count cannot overflow: max value 2^IN_W fits in IN_W+1 bits.
- vec wrap-around never occurs; the terminal check precedes the increment.
- Reset mid-sweep: immediate return to IDLE with all outputs at reset values; partial results are lost.

Optional Feature:
SWEEP_EARLY_ABORT_EN
- Defined: the first violating vector in CHECK goes directly to DONE. Result is err_count=1, pass=0, fail_vec=that vector, max_err=its err.
- Undefined: the full sweep always completes.

Decomposition:
Shared package approx_sweep_pkg holds:
- state enum (IDLE, DRIVE, CHECK, DONE);
- function exact_mul(vec) returning the truncated product;
- function abs_err(x, y).

Sub-module approx_err_unit (combinational: vec, dut_out -> err, violate) holds the arithmetic. The controller holds the FSM, counters and statistics.

Test Plan:
1. Exact DUT model (dut_out=a*b), defaults -> done at edge 33; max_err=0, err_count=0, pass=1, fail_vec=0.
2. Stuck-at-zero DUT (dut_out=0) -> max_err=9, err_count=6, pass=0, fail_vec=4'd7 (a=3, b=1).
3. Offset DUT (dut_out=a*b+1) -> max_err=1, err_count=0, pass=1.
4. Pulse start repeatedly while busy and during the DONE cycle -> ignored; single done pulse; results identical to scenario 2. A start one cycle after DONE begins a new sweep with cleared stats.
5. rst_n low at edge 10 of the stuck-at-zero sweep -> outputs at reset values next sample; a new start gives a full, correct sweep.
6. SWEEP_EARLY_ABORT_EN defined, stuck-at-zero DUT -> done at edge 17; err_count=1, max_err=3, fail_vec=7, pass=0.
